// File: rtl/mult4_pkg.sv
// Shared constants for the sequential 4x4 shift-and-add multiplier.
package mult4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_ITER = 4;

    // Count value seen on the final iteration.
    localparam logic [1:0] CNT_LAST = 2'(N_ITER - 1);

endpackage

// File: rtl/fulladd4.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
module fulladd4 (
    input  logic [3:0] a_94,
    input  logic [3:0] b_94,
    input  logic       cin_94,
    output logic [3:0] sum_94,
    output logic       cout_94
);

    logic [4:0] carry;

    // Ripple the carry bit by bit, LSB first.
    always_comb begin
        carry    = '0;
        sum_94   = '0;
        carry[0] = cin_94;
        for (int i = 0; i < 4; i++) begin
            sum_94[i]  = a_94[i] ^ b_94[i] ^ carry[i];
            carry[i+1] = (a_94[i] & b_94[i]) | (carry[i] & (a_94[i] ^ b_94[i]));
        end
        cout_94 = carry[4];
    end

endmodule

// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned multiplier: one add/shift iteration per cycle
// through the shared fulladd4, product registered after four iterations.
module mult4_seq
    import mult4_pkg::*;
(
    input  logic       clk_94,
    input  logic       rst_n_94,
    input  logic       start_94,
    input  logic [3:0] a_94,
    input  logic [3:0] b_94,
    output logic [7:0] prod_94,
    output logic       busy_94,
    output logic       done_94
);

    state_e     state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] acc_q,   acc_d;
    logic [3:0] q_q,     q_d;
    logic [1:0] cnt_q,   cnt_d;
    logic [7:0] prod_q,  prod_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    logic [3:0] addend;
    logic [3:0] sum;
    logic       cout;
    logic [8:0] shifted;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign addend  = q_q[0] ? mcand_q : 4'b0;
    // 9-bit right shift keeps the adder carry as the new MSB.
    assign shifted = {cout, sum, q_q[3:1]};

    fulladd4 u_add (
        .a_94    (acc_q),
        .b_94    (addend),
        .cin_94  (1'b0),
        .sum_94  (sum),
        .cout_94 (cout)
    );

    // Next-state and datapath update; outputs decoded from the next state.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_94) begin
                    mcand_d = a_94;
                    q_d     = b_94;
                    acc_d   = 4'b0;
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                {acc_d, q_d} = shifted;
                if (cnt_q == CNT_LAST) begin
                    prod_d  = shifted[7:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            // Unused encoding recovers to IDLE.
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Register all state; synchronous reset wins over everything.
    always_ff @(posedge clk_94) begin
        if (!rst_n_94) begin
            state_q <= IDLE;
            mcand_q <= 4'b0;
            acc_q   <= 4'b0;
            q_q     <= 4'b0;
            cnt_q   <= 2'd0;
            prod_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign prod_94 = prod_q;
    assign busy_94 = busy_q;
    assign done_94 = done_q;

endmodule

// File: tb/tb_mult4_seq.sv
// Directed bench for mult4_seq: reset, corner products, ignored start,
// back-to-back starts, mid-run reset and a full operand sweep.
module tb_mult4_seq;

    logic       clk_94;
    logic       rst_n_94;
    logic       start_94;
    logic [3:0] a_94;
    logic [3:0] b_94;
    logic [7:0] prod_94;
    logic       busy_94;
    logic       done_94;

    int n_tests = 0;
    int n_fail  = 0;

    mult4_seq dut (
        .clk_94   (clk_94),
        .rst_n_94 (rst_n_94),
        .start_94 (start_94),
        .a_94     (a_94),
        .b_94     (b_94),
        .prod_94  (prod_94),
        .busy_94  (busy_94),
        .done_94  (done_94)
    );

    initial clk_94 = 1'b0;
    always #5 clk_94 = ~clk_94;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One start pulse, then track the operation to its DONE cycle.
    task automatic run_mul(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp, input bit full);
        @(negedge clk_94);
        start_94 = 1'b1;
        a_94     = a;
        b_94     = b;
        @(negedge clk_94);
        start_94 = 1'b0;
        a_94     = ~a;
        b_94     = ~b;
        if (full) chk("busy_c1", {7'b0, busy_94}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_94);
            if (full) chk("busy_run", {7'b0, busy_94}, 8'd1);
            if (full) chk("done_run", {7'b0, done_94}, 8'd0);
        end
        @(negedge clk_94);
        chk("done_pulse", {7'b0, done_94}, 8'd1);
        chk("prod", prod_94, exp);
        if (full) chk("busy_done", {7'b0, busy_94}, 8'd0);
    endtask

    initial begin
        rst_n_94 = 1'b0;
        start_94 = 1'b0;
        a_94     = 4'h0;
        b_94     = 4'h0;
        repeat (2) @(negedge clk_94);
        chk("rst_prod", prod_94, 8'h00);
        chk("rst_busy", {7'b0, busy_94}, 8'd0);
        chk("rst_done", {7'b0, done_94}, 8'd0);
        rst_n_94 = 1'b1;

        // Corner and directed products.
        run_mul(4'hF, 4'hF, 8'hE1, 1'b1);
        @(negedge clk_94);
        chk("done_drop", {7'b0, done_94}, 8'd0);
        chk("prod_hold", prod_94, 8'hE1);
        run_mul(4'h9, 4'h6, 8'h36, 1'b1);
        run_mul(4'h0, 4'hB, 8'h00, 1'b1);
        run_mul(4'h7, 4'h1, 8'h07, 1'b1);

        // Start during RUN is ignored.
        @(negedge clk_94);
        start_94 = 1'b1; a_94 = 4'h3; b_94 = 4'h5;
        @(negedge clk_94);
        start_94 = 1'b0;
        @(negedge clk_94);
        start_94 = 1'b1; a_94 = 4'hF; b_94 = 4'hF;
        @(negedge clk_94);
        chk("ign_busy", {7'b0, busy_94}, 8'd1);
        @(negedge clk_94);
        start_94 = 1'b0;
        chk("ign_busy2", {7'b0, busy_94}, 8'd1);
        @(negedge clk_94);
        chk("ign_done", {7'b0, done_94}, 8'd1);
        chk("ign_prod", prod_94, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_94);
            chk("ign_no_extra_done", {7'b0, done_94}, 8'd0);
            chk("ign_idle_busy", {7'b0, busy_94}, 8'd0);
        end

        // Continuous start: back-to-back products every 5 cycles.
        start_94 = 1'b1; a_94 = 4'h2; b_94 = 4'h3;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk_94);
                chk("b2b_busy", {7'b0, busy_94}, 8'd1);
                chk("b2b_nodone", {7'b0, done_94}, 8'd0);
            end
            @(negedge clk_94);
            chk("b2b_done", {7'b0, done_94}, 8'd1);
            chk("b2b_prod", prod_94, 8'h06);
        end
        start_94 = 1'b0;

        // Reset in RUN cycle 2 aborts the operation.
        @(negedge clk_94);
        start_94 = 1'b1; a_94 = 4'hF; b_94 = 4'hF;
        @(negedge clk_94);
        start_94 = 1'b0;
        @(negedge clk_94);
        rst_n_94 = 1'b0;
        @(negedge clk_94);
        rst_n_94 = 1'b1;
        chk("mid_rst_busy", {7'b0, busy_94}, 8'd0);
        chk("mid_rst_prod", prod_94, 8'h00);
        chk("mid_rst_done", {7'b0, done_94}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_94);
            chk("mid_rst_nodone", {7'b0, done_94}, 8'd0);
        end
        run_mul(4'h2, 4'h2, 8'h04, 1'b1);

        // Full operand sweep against a*b.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_mul(4'(ia), 4'(ib), 8'(ia * ib), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult4_seq.md
# mult4_seq

Sequential 4x4 unsigned shift-and-add multiplier built directly downstream of the `fulladd4` ripple adder. Each iteration feeds the adder with the partial-product upper nibble and the multiplicand, then consumes its sum and carry. The block accepts one operand pair per start pulse and produces an 8-bit product after four add/shift iterations. It is the next arithmetic stage of the lab datapath and reuses the existing adder rather than a `*` operator.

## Interface
- Parameters: none. Width is fixed at 4 bits by the `fulladd4` adder.
- `clk_94`  in  1  single clock; all state updates on its rising edge.
- `rst_n_94`  in  1  reset, synchronous, active-low.
- `start_94`  in  1  request to begin; sampled only in IDLE or DONE.
- `a_94`  in  4  multiplicand, unsigned; captured on the accepted start.
- `b_94`  in  4  multiplier, unsigned; captured on the accepted start.
- `prod_94`  out  8  product register; holds its last result.
- `busy_94`  out  1  high while in RUN.
- `done_94`  out  1  one-cycle pulse, high while in DONE.

## Operation
- Internal registers:
  - `mcand[3:0]`: multiplicand.
  - `acc[3:0]`: upper partial product.
  - `q[3:0]`: multiplier, shifted out LSB-first; low product bits shift in.
  - `cnt[1:0]`: iteration count.
  - `state`.
- State machine:
  - IDLE: `start_94`=1 captures operands, clears `acc`/`cnt`, goes to RUN. Otherwise stays in IDLE.
  - RUN: one iteration per cycle. When `cnt`==3, the iteration completes, `prod_94` loads, and the FSM goes to DONE. Otherwise `cnt`+1.
  - DONE: `start_94`=1 behaves as in IDLE and goes to RUN (back-to-back). Otherwise goes to IDLE.
- Iteration, where {c,s} is the `fulladd4` result:
  - The adder computes `acc + (q[0] ? mcand : 4'b0)` with cin=0.
  - Next `{acc,q}` = `{c, s, q[3:1]}`, a 9-bit right shift that keeps the carry.
- `prod_94` = `{acc,q}` after the 4th iteration. It is written only on the RUN→DONE transition.
- `start_94` in RUN is ignored. The operands in flight are not disturbed.
- `a_94`/`b_94` are sampled only on the accepting edge; later changes have no effect.
- Arithmetic is unsigned. The max product 15×15=225 fits in 8 bits, so there is no overflow flag.

## Timing
- Reset (`rst_n_94`=0 at a rising edge):
  - state is IDLE.
  - `prod_94`=8'h00, `busy_94`=0, `done_94`=0.
  - `acc`, `q`, `mcand`, `cnt` are all 0.
- Reset has priority over `start_94` and over a RUN iteration. Reset mid-RUN aborts the operation; no `done_94` pulse and no product is produced.
- Edge E0 accepts start. Edges E1–E4 perform iterations 1–4; E4 loads `prod_94`.
- `busy_94`=1 in the cycles between E0 and E4.
- `done_94`=1 for exactly the one cycle between E4 and E5, with `prod_94` already valid.
- Latency: start edge to `done_94` high is 4 cycles. Throughput is one product per 5 cycles, or per 5 cycles back-to-back via a start in DONE.
- Outputs are registered or decoded from state only. No combinational path runs from inputs to outputs.

## Structure
- Shared package `mult4_pkg`:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - `N_ITER`=4.
  - Encoding 2'd3 is unreachable and decodes to IDLE on the next edge.
- One sub-module instance: the existing `fulladd4`, with cin tied to 0 and the operand gated by `q[0]`.
- The carry output (`cout_94`) is consumed by the shift.
- The control FSM and datapath stay in `mult4_seq`; no further hierarchy.

## Test plan
- Reset, then a=4'hF, b=4'hF, start pulse:
  - `busy_94` high for 4 cycles;
  - `done_94` pulses in cycle 5 with `prod_94`=8'hE1 (225);
  - the carry path is exercised.
- a=4'h9, b=4'h6 → `prod_94`=8'h36 (54). Then a=4'h0, b=4'hB → `prod_94`=8'h00. Then a=4'h7, b=4'h1 → 8'h07.
- a=3, b=5 started. Assert `start_94` with a=F, b=F during RUN cycles 2–3 → ignored; result is 8'h0F; exactly one `done_94`.
- Hold `start_94`=1 continuously with a=2, b=3 → products 8'h06 every 5 cycles; `done_94` pulses each DONE cycle.
- Start a=F, b=F, assert `rst_n_94`=0 in RUN cycle 2:
  - next cycle `busy_94`=0, `prod_94`=8'h00;
  - no `done_94` pulse;
  - a fresh start of a=2, b=2 yields 8'h04.
- Exhaustive 256-pair sweep against a reference model of a×b.
